// File: rtl/panda_pkg.sv
// Shared types for the panda core.
// Holds the load/store width encoding, the load/store FSM state encoding
// and the alignment check used when the LSU accepts a request.
package panda_pkg;

    typedef enum logic [1:0] {
        LSU_BYTE      = 2'b00,
        LSU_HALF      = 2'b01,
        LSU_WORD      = 2'b10,
        LSU_WIDTH_ILL = 2'b11
    } lsu_width_e;

    typedef enum logic [1:0] {
        LSU_IDLE        = 2'b00,
        LSU_WAIT_GNT    = 2'b01,
        LSU_WAIT_RVALID = 2'b10
    } lsu_state_e;

    // An illegal width is rejected the same way as a misaligned address.
    function automatic logic lsu_misaligned(lsu_width_e width, logic [1:0] addr_lo);
        logic bad;
        case (width)
            LSU_BYTE: bad = 1'b0;
            LSU_HALF: bad = addr_lo[0];
            LSU_WORD: bad = (addr_lo != 2'b00);
            default:  bad = 1'b1;
        endcase
        return bad;
    endfunction

endpackage

// File: rtl/panda_lsu_align.sv
// Data-path helpers for the load/store unit (purely combinational).
// Request side : byte enables and store-data replication from width/addr[1:0].
// Response side: load data shifted down by addr[1:0] bytes, then sign/zero-extended.
// Ports:
//   req_width_i, req_addr_lo_i, req_wdata_i -> req_be_o, req_wdata_o
//   rsp_width_i, rsp_addr_lo_i, rsp_unsigned_i, rsp_rdata_i -> rsp_rdata_o
module panda_lsu_align
    import panda_pkg::*;
(
    input  lsu_width_e  req_width_i,
    input  logic [1:0]  req_addr_lo_i,
    input  logic [31:0] req_wdata_i,
    output logic [3:0]  req_be_o,
    output logic [31:0] req_wdata_o,
    input  lsu_width_e  rsp_width_i,
    input  logic [1:0]  rsp_addr_lo_i,
    input  logic        rsp_unsigned_i,
    input  logic [31:0] rsp_rdata_i,
    output logic [31:0] rsp_rdata_o
);

    logic [31:0] rdata_shifted;

    assign rdata_shifted = rsp_rdata_i >> {rsp_addr_lo_i, 3'b000};

    always_comb begin
        req_be_o    = 4'b0000;
        req_wdata_o = 32'h0;
        case (req_width_i)
            LSU_BYTE: begin
                req_be_o    = 4'b0001 << req_addr_lo_i;
                req_wdata_o = {4{req_wdata_i[7:0]}};
            end
            LSU_HALF: begin
                req_be_o    = 4'b0011 << {req_addr_lo_i[1], 1'b0};
                req_wdata_o = {2{req_wdata_i[15:0]}};
            end
            LSU_WORD: begin
                req_be_o    = 4'b1111;
                req_wdata_o = req_wdata_i;
            end
            default: ;
        endcase
    end

    always_comb begin
        rsp_rdata_o = 32'h0;
        case (rsp_width_i)
            LSU_BYTE: rsp_rdata_o = {{24{~rsp_unsigned_i & rdata_shifted[7]}},  rdata_shifted[7:0]};
            LSU_HALF: rsp_rdata_o = {{16{~rsp_unsigned_i & rdata_shifted[15]}}, rdata_shifted[15:0]};
            LSU_WORD: rsp_rdata_o = rdata_shifted;
            default:  ;
        endcase
    end

endmodule

// File: rtl/panda_lsu_ctrl.sv
// Load/store unit controller: sequences the single data-memory port.
// Accepts an aligned EX-stage request, runs one req/gnt/rvalid transaction,
// stalls the pipeline until it completes and returns extended load data.
// Ports:
//   clk_i, rst_ni                          clock, async active-low reset
//   req_i, store_i, width_i, load_unsigned_i, addr_i, wdata_i   EX request
//   stall_o, done_o, rdata_o, rdata_valid_o, misaligned_o, err_o  to pipeline
//   data_req_o, data_gnt_i, data_we_o, data_be_o, data_addr_o,
//   data_wdata_o, data_rvalid_i, data_rdata_i, data_err_i        data bus
//
// state           | meaning
// LSU_IDLE        | no access in flight; checks and accepts requests
// LSU_WAIT_GNT    | data_req_o asserted, waiting for data_gnt_i
// LSU_WAIT_RVALID | granted, waiting for data_rvalid_i
module panda_lsu_ctrl
    import panda_pkg::*;
#(
    parameter int unsigned BUS_TIMEOUT = 0
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        req_i,
    input  logic        store_i,
    input  lsu_width_e  width_i,
    input  logic        load_unsigned_i,
    input  logic [31:0] addr_i,
    input  logic [31:0] wdata_i,
    output logic        stall_o,
    output logic        done_o,
    output logic [31:0] rdata_o,
    output logic        rdata_valid_o,
    output logic        misaligned_o,
    output logic        err_o,
    output logic        data_req_o,
    input  logic        data_gnt_i,
    output logic        data_we_o,
    output logic [3:0]  data_be_o,
    output logic [31:0] data_addr_o,
    output logic [31:0] data_wdata_o,
    input  logic        data_rvalid_i,
    input  logic [31:0] data_rdata_i,
    input  logic        data_err_i
);

    localparam int unsigned CNT_W = (BUS_TIMEOUT > 1) ? $clog2(BUS_TIMEOUT) : 1;
    // Only meaningful when BUS_TIMEOUT != 0; every use is qualified by that.
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BUS_TIMEOUT - 1);

    lsu_state_e       state_q, state_d;
    logic [31:0]      addr_q, addr_d;
    logic [3:0]       be_q, be_d;
    logic [31:0]      wdata_q, wdata_d;
    lsu_width_e       width_q, width_d;
    logic             unsigned_q, unsigned_d;
    logic             we_q, we_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic [3:0]  req_be;
    logic [31:0] req_wdata;
    logic [31:0] ld_data;
    logic        in_idle, in_gnt, in_rvalid;
    logic        req_live, bad_req, accept;
    logic        rsp_fire, timeout;

    panda_lsu_align u_align (
        .req_width_i    (width_i),
        .req_addr_lo_i  (addr_i[1:0]),
        .req_wdata_i    (wdata_i),
        .req_be_o       (req_be),
        .req_wdata_o    (req_wdata),
        .rsp_width_i    (width_q),
        .rsp_addr_lo_i  (addr_q[1:0]),
        .rsp_unsigned_i (unsigned_q),
        .rsp_rdata_i    (data_rdata_i),
        .rsp_rdata_o    (ld_data)
    );

    assign in_idle   = (state_q == LSU_IDLE);
    assign in_gnt    = (state_q == LSU_WAIT_GNT);
    assign in_rvalid = (state_q == LSU_WAIT_RVALID);

    // Gating with rst_ni keeps every output at 0 while reset is held,
    // even if the pipeline is still presenting a request.
    assign req_live = rst_ni & req_i & in_idle;
    assign bad_req  = lsu_misaligned(width_i, addr_i[1:0]);
    assign accept   = req_live & ~bad_req;

    assign rsp_fire = in_rvalid & data_rvalid_i;
    // The counter spans both wait states; a response in the last cycle wins.
    assign timeout  = (BUS_TIMEOUT != 0) && (cnt_q == CNT_LAST) &&
                      ((in_gnt & ~data_gnt_i) | (in_rvalid & ~data_rvalid_i));

    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        be_d       = be_q;
        wdata_d    = wdata_q;
        width_d    = width_q;
        unsigned_d = unsigned_q;
        we_d       = we_q;
        cnt_d      = in_idle ? '0 : cnt_q + 1'b1;
        case (state_q)
            LSU_IDLE: begin
                if (accept) begin
                    state_d    = LSU_WAIT_GNT;
                    addr_d     = addr_i;
                    be_d       = req_be;
                    wdata_d    = req_wdata;
                    width_d    = width_i;
                    unsigned_d = load_unsigned_i;
                    we_d       = store_i;
                end
            end
            LSU_WAIT_GNT: begin
                if (data_gnt_i)   state_d = LSU_WAIT_RVALID;
                else if (timeout) state_d = LSU_IDLE;
            end
            LSU_WAIT_RVALID: begin
                if (data_rvalid_i || timeout) state_d = LSU_IDLE;
            end
            default: state_d = LSU_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= LSU_IDLE;
            addr_q     <= 32'h0;
            be_q       <= 4'b0000;
            wdata_q    <= 32'h0;
            width_q    <= LSU_BYTE;
            unsigned_q <= 1'b0;
            we_q       <= 1'b0;
            cnt_q      <= '0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            be_q       <= be_d;
            wdata_q    <= wdata_d;
            width_q    <= width_d;
            unsigned_q <= unsigned_d;
            we_q       <= we_d;
            cnt_q      <= cnt_d;
        end
    end

    assign done_o        = rsp_fire | timeout;
    assign err_o         = (rsp_fire & data_err_i) | timeout;
    assign rdata_valid_o = rsp_fire & ~data_err_i & ~we_q;
    assign rdata_o       = rdata_valid_o ? ld_data : 32'h0;
    assign misaligned_o  = req_live & bad_req;
    assign stall_o       = accept | (~in_idle & ~done_o);

    assign data_req_o   = in_gnt;
    assign data_we_o    = we_q;
    assign data_be_o    = be_q;
    assign data_addr_o  = {addr_q[31:2], 2'b00};
    assign data_wdata_o = wdata_q;

endmodule
